rrf: RTL and testbench
======================

# rrf

Retirement register file (retirement RAT) for the out-of-order core; sits directly downstream of the reorder buffer. It consumes one committed instruction per cycle as a (physical, architectural) register pair and updates the committed arch-to-phys map. It returns the physical register displaced by that commit to the free list through a small buffered valid/ready channel. The full committed map is exported for flush recovery of the speculative RAT.

## Interface
- NUM_ARCH_REGS, 32, architectural registers; map index width 5
- PHYS_W, 6, physical register index width (64 physical regs)
- FREE_BUF_DEPTH, 4, entries in freed-register buffer; power of two, at least 2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- commit_valid  in  1  ROB presents a committing instruction
- commit_phys  in  PHYS_W  physical destination of committing instruction
- commit_arch  in  5  architectural destination of committing instruction
- commit_ready  out  1  RRF accepts commit this cycle
- free_valid  out  1  a freed physical register is available
- free_phys  out  PHYS_W  freed physical register index
- free_ready  in  1  free list accepts free_phys this cycle
- rrat_map  out  NUM_ARCH_REGS*PHYS_W  committed map; arch i occupies bits [i*PHYS_W +: PHYS_W]
- commit_count  out  32  retired-instruction counter; present only with RRF_PERF_CNT_EN

## Operation
- State: map[NUM_ARCH_REGS] of PHYS_W bits; circular buffer buf[FREE_BUF_DEPTH] with head/tail pointers plus one extra wrap bit each.
- Reset: map[i] = i for all i, so arch i maps to phys i. Buffer is empty: head = tail = 0.
- Reset output values:
  - commit_ready = 1
  - free_valid = 0
  - free_phys = 0
  - rrat_map = identity
  - commit_count = 0
- Commit fires when commit_valid && commit_ready.
- commit_arch == 0: no map write and no buffer push. Rename never allocates for x0. commit_count still increments.
- commit_arch != 0:
  - old = map[commit_arch]
  - map[commit_arch] <= commit_phys
  - buf[tail] <= old; tail increments
- Pop fires when free_valid && free_ready; head increments.
- Buffer state:
  - full = low pointer bits equal and wrap bits differ
  - empty = pointers fully equal
- commit_ready = !full. This is conservative: a commit is refused while full even if a pop fires the same cycle.
- Simultaneous push and pop when neither full nor empty: both pointers advance; occupancy is unchanged.
- free_valid = !empty; free_phys = buf[head[low bits]].
- Pointers wrap modulo FREE_BUF_DEPTH; the wrap bit toggles on wrap.
- Values are not checked: commit_phys is trusted to be unique and nonzero, and duplicates are not detected.
- rrat_map is driven directly from the map registers.

## Timing
- Commit-to-map latency is 1 cycle: a map write is visible on rrat_map the cycle after the commit edge.
- Commit-to-free latency is 1 cycle: the displaced register appears on free_phys at the earliest the cycle after commit. There is no empty-buffer bypass.
- Back-to-back commits to the same arch reg: the second reads the map already updated by the first, so it frees the first commit's commit_phys.
- commit_ready depends only on registered state; it has no combinational path from free_ready or commit_valid.
- free_phys and free_valid must be held stable while free_valid && !free_ready.
- rst asserted mid-operation: all state returns to reset values at the next edge; buffered frees are discarded. The free list is reset in the same cycle.

## Configuration
- RRF_PERF_CNT_EN defined:
  - commit_count port and a 32-bit register exist.
  - The register increments by 1 per fired commit, including arch 0, and wraps at 2^32.
  - It resets to 0.
- RRF_PERF_CNT_EN undefined: the port and register are absent; all other behaviour is identical.

## Test plan
- Reset then idle:
  - rrat_map slice i == i for all 32 entries.
  - free_valid = 0, commit_ready = 1.
- Commit (phys 40, arch 5) with free_ready = 1:
  - Next cycle, rrat_map slice 5 == 40, free_valid = 1, free_phys = 5.
  - The following cycle, free_valid = 0.
- Commit (phys 41, arch 0): map unchanged, free_valid stays 0; commit_count +1 with RRF_PERF_CNT_EN.
- Hold free_ready = 0 and commit arch 1..5 with phys 33..37:
  - After 4 commits, commit_ready = 0 and the fifth is held.
  - Raise free_ready: frees 1, 2, 3, 4 emerge in order, then the fifth commit is accepted, freeing 5.
- Back-to-back commits (phys 50, arch 7) then (phys 51, arch 7): frees are 7 then 50; final slice 7 == 51.
- Mid-stream rst with 3 buffered frees: next cycle free_valid = 0, map is identity, commit_count = 0.

Source files
------------

// File: rtl/rrf.sv
// Retirement RAT: committed arch->phys map, frees displaced phys regs through a small buffer.
// Latency: map write and freed register visible 1 cycle after the commit edge; no bypass.
// Backpressure: commit_ready drops while the free buffer is full. RRF_PERF_CNT_EN adds commit_count.
module rrf #(
   parameter int NUM_ARCH_REGS  = 32,
   parameter int PHYS_W         = 6,
   parameter int FREE_BUF_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            commit_valid,
   input  logic [PHYS_W-1:0]               commit_phys,
   input  logic [$clog2(NUM_ARCH_REGS)-1:0] commit_arch,
   output logic                            commit_ready,
   output logic                            free_valid,
   output logic [PHYS_W-1:0]               free_phys,
   input  logic                            free_ready,
   output logic [NUM_ARCH_REGS*PHYS_W-1:0] rrat_map
`ifdef RRF_PERF_CNT_EN
   ,
   output logic [31:0]                     commit_count
`endif
);

   localparam int PW = $clog2(FREE_BUF_DEPTH);

   logic [PHYS_W-1:0] map_q  [NUM_ARCH_REGS];
   logic [PHYS_W-1:0] fbuf_q [FREE_BUF_DEPTH];
   logic [PW:0]       head_q;
   logic [PW:0]       tail_q;
   logic              full;
   logic              empty;
   logic              commit_fire;
   logic              pop_fire;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign full         = (head_q[PW-1:0] == tail_q[PW-1:0]) && (head_q[PW] != tail_q[PW]);
   assign empty        = (head_q == tail_q);
   assign commit_ready = !full;
   assign commit_fire  = commit_valid && commit_ready;
   assign free_valid   = !empty;
   assign free_phys    = fbuf_q[head_q[PW-1:0]];
   assign pop_fire     = free_valid && free_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ARCH_REGS; i++)
            map_q[i] <= PHYS_W'(i);
         for (int i = 0; i < FREE_BUF_DEPTH; i++)
            fbuf_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         // x0 is never renamed, so a commit to it displaces nothing.
         if (commit_fire && commit_arch != '0) begin
            map_q[commit_arch]       <= commit_phys;
            fbuf_q[tail_q[PW-1:0]]   <= map_q[commit_arch];
            tail_q                   <= tail_q + 1'b1;
         end
         if (pop_fire)
            head_q <= head_q + 1'b1;
      end
   end

   always_comb begin
      rrat_map = '0;
      for (int i = 0; i < NUM_ARCH_REGS; i++)
         rrat_map[i*PHYS_W +: PHYS_W] = map_q[i];
   end

`ifdef RRF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         commit_count <= '0;
      else if (commit_fire)
         commit_count <= commit_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_rrf.sv
// Directed bench for rrf: reset map, commit/free flow, full-buffer stall, back-to-back, mid-run reset.
module tb_rrf;
   localparam int NA = 32;
   localparam int PW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          commit_valid;
   logic [PW-1:0] commit_phys;
   logic [4:0]    commit_arch;
   logic          commit_ready;
   logic          free_valid;
   logic [PW-1:0] free_phys;
   logic          free_ready;
   logic [NA*PW-1:0] rrat_map;
`ifdef RRF_PERF_CNT_EN
   logic [31:0]   commit_count;
`endif

   int total = 0;
   int bad   = 0;

   rrf dut (
      .clk          (clk),
      .rst          (rst),
      .commit_valid (commit_valid),
      .commit_phys  (commit_phys),
      .commit_arch  (commit_arch),
      .commit_ready (commit_ready),
      .free_valid   (free_valid),
      .free_phys    (free_phys),
      .free_ready   (free_ready),
      .rrat_map     (rrat_map)
`ifdef RRF_PERF_CNT_EN
      ,
      .commit_count (commit_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] slice(input int i);
      return rrat_map[i*PW +: PW];
   endfunction

   task automatic do_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_identity(input string tag);
      for (int i = 0; i < NA; i++)
         check($sformatf("%s_map%0d", tag, i), 64'(slice(i)), 64'(i));
   endtask

   task automatic commit1(input int phys, input int arch);
      commit_valid = 1'b1;
      commit_phys  = PW'(phys);
      commit_arch  = 5'(arch);
      tick();
      commit_valid = 1'b0;
   endtask

   initial begin
      int exp_free [5];
      int n;
      bit accepted;
      bit fire;

      rst = 1'b1; commit_valid = 1'b0; commit_phys = '0; commit_arch = '0; free_ready = 1'b0;
      do_reset();

      // Reset / idle state
      check_identity("rst");
      check("rst_free_valid", 64'(free_valid), 64'd0);
      check("rst_free_phys", 64'(free_phys), 64'd0);
      check("rst_commit_ready", 64'(commit_ready), 64'd1);
`ifdef RRF_PERF_CNT_EN
      check("rst_count", 64'(commit_count), 64'd0);
`endif

      // Single commit (phys 40 -> arch 5)
      free_ready = 1'b1;
      commit1(40, 5);
      check("c1_map5", 64'(slice(5)), 64'd40);
      check("c1_free_valid", 64'(free_valid), 64'd1);
      check("c1_free_phys", 64'(free_phys), 64'd5);
      tick();
      check("c1_drained", 64'(free_valid), 64'd0);

      // Commit to x0
      commit1(41, 0);
      check("x0_map0", 64'(slice(0)), 64'd0);
      check("x0_map5", 64'(slice(5)), 64'd40);
      check("x0_free_valid", 64'(free_valid), 64'd0);
`ifdef RRF_PERF_CNT_EN
      check("x0_count", 64'(commit_count), 64'd2);
`endif

      // Fill buffer with free_ready low, fifth commit must stall
      do_reset();
      free_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("fill_ready%0d", k), 64'(commit_ready), 64'd1);
         commit1(33 + k, 1 + k);
      end
      commit_valid = 1'b1; commit_phys = PW'(37); commit_arch = 5'd5;
      check("full_ready", 64'(commit_ready), 64'd0);
      check("full_head", 64'(free_phys), 64'd1);
      tick();
      check("full_held_ready", 64'(commit_ready), 64'd0);
      check("full_held_map5", 64'(slice(5)), 64'd5);
      check("full_held_phys", 64'(free_phys), 64'd1);

      free_ready = 1'b1;
      exp_free = '{1, 2, 3, 4, 5};
      n = 0;
      accepted = 1'b0;
      for (int cyc = 0; cyc < 20 && n < 5; cyc++) begin
         if (free_valid) begin
            check($sformatf("drain_free%0d", n), 64'(free_phys), 64'(exp_free[n]));
            n++;
         end
         fire = commit_valid && commit_ready;
         tick();
         if (fire) begin
            commit_valid = 1'b0;
            accepted = 1'b1;
         end
      end
      check("drain_count", 64'(n), 64'd5);
      check("drain_accepted", 64'(accepted), 64'd1);
      check("drain_empty", 64'(free_valid), 64'd0);
      for (int k = 0; k < 5; k++)
         check($sformatf("drain_map%0d", k + 1), 64'(slice(k + 1)), 64'(33 + k));

      // Back-to-back commits to arch 7
      commit_valid = 1'b1; commit_phys = PW'(50); commit_arch = 5'd7;
      tick();
      check("b2b_free0", 64'(free_phys), 64'd7);
      check("b2b_valid0", 64'(free_valid), 64'd1);
      commit_phys = PW'(51);
      tick();
      commit_valid = 1'b0;
      check("b2b_free1", 64'(free_phys), 64'd50);
      check("b2b_valid1", 64'(free_valid), 64'd1);
      tick();
      check("b2b_map7", 64'(slice(7)), 64'd51);
      check("b2b_empty", 64'(free_valid), 64'd0);

      // Mid-stream reset with three buffered frees
      free_ready = 1'b0;
      commit1(20, 10);
      commit1(21, 11);
      commit1(22, 12);
      check("pre_rst_valid", 64'(free_valid), 64'd1);
      check("pre_rst_map12", 64'(slice(12)), 64'd22);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", 64'(free_valid), 64'd0);
      check("mid_rst_ready", 64'(commit_ready), 64'd1);
      check("mid_rst_phys", 64'(free_phys), 64'd0);
      check_identity("mid_rst");
`ifdef RRF_PERF_CNT_EN
      check("mid_rst_count", 64'(commit_count), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
